alu_result_fifo: RTL and testbench
==================================

# alu_result_fifo

Downstream buffer for the 4-bit ALU: captures each ALU result together with the opcode that produced it and holds it in a small FIFO until the pad-side consumer drains it over a valid/ready handshake. The ALU is combinational and cannot stall, so this block absorbs bursts, counts occupancy and flags any result dropped while full. It sits between the ALU datapath and the `uo_out` output mux in the top-level wrapper.

## Interface
Parameters:
- `DEPTH`, 4: number of entries. Must be a power of two and ≥ 2.
- `DATA_W`, 8: width of the ALU result.
- `OP_W`, 4: width of the opcode tag.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  ALU result present this cycle.
- `in_ready`  out  1  FIFO can accept a push. Equals `!full`, decoded from registered state only.
- `in_result`  in  DATA_W  ALU result.
- `in_op`  in  OP_W  opcode that produced `in_result`.
- `out_valid`  out  1  head entry available. Equals `!empty`.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_result`  out  DATA_W  head entry result.
- `out_op`  out  OP_W  head entry opcode.
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a result was dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation
- Push: `in_valid && in_ready` writes `{in_op,in_result}` at the write pointer. The write pointer advances modulo DEPTH.
- Pop: `out_valid && out_ready` advances the read pointer modulo DEPTH.
- Drop: `in_valid && !in_ready` discards the result and sets `overflow`. Storage, pointers and `count` are unchanged.
- Push and pop in the same cycle:
  - Both occur when neither full nor empty; `count` is unchanged.
  - When full, `in_ready` is 0. The pop proceeds and the push is a drop (sets `overflow`).
  - When empty, `out_valid` is 0. Only the push proceeds.
- `count` tracks pushes minus pops.
  - full = (`count` == DEPTH).
  - empty = (`count` == 0).
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by `count`, never by pointer equality.
- `overflow`:
  - Set by a drop.
  - Cleared by `clear_ovf`.
  - When a drop and `clear_ovf` occur in the same cycle, set wins.
- `out_result`/`out_op` are a combinational read of the storage entry at the read pointer. Their value is don't-care while `out_valid` is 0, and the bench must not check it then.
- Storage is not reset. Only pointers, `count` and `overflow` are reset.

## Timing
- Reset (async assert, release synchronous to `clk` in the wrapper) gives:
  - `count`=0, pointers=0, `overflow`=0.
  - Hence `in_ready`=1 and `out_valid`=0.
- Reset mid-operation discards all entries immediately. No pop completes in the reset cycle.
- Push-to-output latency is 1 cycle: a push at edge N gives `out_valid`=1 with that data after edge N.
- Pop takes effect at the edge. The next entry, or `out_valid`=0, is visible after that edge.
- `in_ready` and `out_valid` have no combinational path from `in_valid` or `out_ready`.
- Throughput: 1 push and 1 pop per cycle in steady state.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_DATA_W`=8 and `ALU_OP_W`=4.
  - The opcode typedef `alu_op_t` with named opcode constants (ADD, SUB, AND, OR, XOR, SHL, SHR, CMP …), so the ALU, this FIFO and the bench agree on tags.
  - The entry struct `alu_entry_t` = {op, result}.
- Single module, no sub-module. Storage is a flop array of `alu_entry_t`. Pointer/count logic sits in one always block with async reset.

## Test plan
- Reset, then 3 pushes (op=ADD, 0x12 / op=SUB, 0x34 / op=AND, 0x56) with `out_ready`=0 → `count`=3, `in_ready`=1, head = ADD/0x12.
- From empty, push 0xA5 at edge N with `out_ready`=1 → `out_valid` rises after N, entry pops at N+1, `count` back to 0.
- Fill 4 entries, then a 5th push of 0xFF → `in_ready`=0, value dropped, `overflow`=1, `count`=4. Draining yields the original 4 in order.
- At `count`=2, hold `in_valid` and `out_ready` high for 10 cycles with incrementing data 0x00..0x09 → `count` stays 2, outputs in order, pointers wrap past DEPTH with no loss.
- Full FIFO with pop and push together → pop of head, push dropped, `overflow` set, `count`=3. Same cycle as a drop with `clear_ovf`=1 → `overflow` stays 1. `clear_ovf` alone the next cycle → 0.
- Assert `rst` mid-burst at `count`=3 → `count`=0, `out_valid`=0 and `overflow`=0 immediately, without waiting for a clock edge. After release, the first push is readable with its own value.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcode tags and FIFO entry type
package alu_pkg;

   localparam int ALU_DATA_W = 8;
   localparam int ALU_OP_W   = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD = 4'h0,
      OP_SUB = 4'h1,
      OP_AND = 4'h2,
      OP_OR  = 4'h3,
      OP_XOR = 4'h4,
      OP_SHL = 4'h5,
      OP_SHR = 4'h6,
      OP_CMP = 4'h7
   } alu_op_t;

   typedef struct packed {
      alu_op_t                 op;
      logic [ALU_DATA_W-1:0]   result;
   } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - buffers ALU results with their opcode until the pad side drains them
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_result,
   input  logic [OP_W-1:0]            in_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_result,
   output logic [OP_W-1:0]            out_op,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   input  logic                       clear_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   alu_entry_t    mem_q [DEPTH];
   alu_entry_t    wr_entry;

   logic full, empty, push, pop, drop;

   // Full/empty come only from the registered count, so the handshakes never see the other side's inputs.
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = in_valid && !full;
   assign pop   = out_ready && !empty;
   assign drop  = in_valid && full;

   assign wr_entry.op     = alu_op_t'(in_op);
   assign wr_entry.result = in_result;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      // A drop in the same cycle as a clear must still be reported.
      if (drop)           overflow_d = 1'b1;
      else if (clear_ovf) overflow_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign in_ready   = !full;
   assign out_valid  = !empty;
   assign out_result = mem_q[rd_ptr_q].result;
   assign out_op     = mem_q[rd_ptr_q].op;
   assign count      = count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - randomized and directed self-checking bench for alu_result_fifo
module tb_alu_result_fifo;
   import alu_pkg::*;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       clear_ovf = 1'b0;
   logic [7:0] in_result = 8'h00;
   logic [3:0] in_op = 4'h0;
   logic       in_ready, out_valid, overflow;
   logic [7:0] out_result;
   logic [3:0] out_op;
   logic [2:0] count;

   int errors = 0;
   int checks = 0;

   logic [11:0] mq[$];
   bit          m_ovf = 1'b0;

   alu_result_fifo #(.DEPTH(DEPTH), .DATA_W(8), .OP_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
      .count(count), .overflow(overflow), .clear_ovf(clear_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a queue of {op,result} with fullness judged before this edge's pop.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         bit was_full, was_empty;
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         if (out_ready && !was_empty) void'(mq.pop_front());
         if (in_valid && !was_full) mq.push_back({in_op, in_result});
         if (in_valid && was_full) m_ovf = 1'b1;
         else if (clear_ovf)       m_ovf = 1'b0;
      end
   end

   always @(negedge clk) begin
      chk("cmp_count", 32'(count), mq.size());
      chk("cmp_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("cmp_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0) begin
         logic [11:0] h;
         h = mq[0];
         chk("cmp_head_result", 32'(out_result), 32'(h[7:0]));
         chk("cmp_head_op", 32'(out_op), 32'(h[11:8]));
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] res, input logic rdy);
      in_valid  = v;
      in_op     = op;
      in_result = res;
      out_ready = rdy;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);

      drive(1, OP_ADD, 8'h12, 0); step();
      drive(1, OP_SUB, 8'h34, 0); step();
      drive(1, OP_AND, 8'h56, 0); step();
      in_valid = 1'b0;
      chk("three_count", 32'(count), 3);
      chk("three_in_ready", 32'(in_ready), 1);
      chk("three_head_op", 32'(out_op), 32'(OP_ADD));
      chk("three_head_result", 32'(out_result), 32'h12);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      chk("drain_count", 32'(count), 0);

      drive(1, OP_XOR, 8'hA5, 1); step();
      in_valid = 1'b0;
      chk("lat_out_valid", 32'(out_valid), 1);
      chk("lat_result", 32'(out_result), 32'hA5);
      step();
      chk("lat_popped_count", 32'(count), 0);
      chk("lat_popped_valid", 32'(out_valid), 0);
      out_ready = 1'b0;

      for (int i = 0; i < 4; i++) begin
         drive(1, 4'(i), 8'(8'h10 + i), 0); step();
      end
      chk("full_in_ready", 32'(in_ready), 0);
      drive(1, OP_CMP, 8'hFF, 0); step();
      in_valid = 1'b0;
      chk("drop_overflow", 32'(overflow), 1);
      chk("drop_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 32'(out_result), 32'(8'h10 + i));
         step();
      end
      out_ready = 1'b0;

      clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
      chk("clear_overflow", 32'(overflow), 0);
      drive(1, OP_OR, 8'hE0, 0); step();
      drive(1, OP_OR, 8'hE1, 0); step();
      for (int i = 0; i < 10; i++) begin
         drive(1, OP_SHR, 8'(i), 1); step();
         chk("stream_count", 32'(count), 2);
      end
      in_valid = 1'b0;
      chk("stream_head", 32'(out_result), 32'h08);
      repeat (2) step();
      out_ready = 1'b0;

      for (int i = 0; i < 4; i++) begin
         drive(1, OP_ADD, 8'(8'h20 + i), 0); step();
      end
      drive(1, OP_SUB, 8'h99, 1); step();
      chk("fullpp_count", 32'(count), 3);
      chk("fullpp_overflow", 32'(overflow), 1);
      chk("fullpp_head", 32'(out_result), 32'h21);
      drive(1, OP_SUB, 8'h30, 0); step();
      drive(1, OP_SUB, 8'h31, 0); clear_ovf = 1'b1; step();
      chk("set_wins", 32'(overflow), 1);
      chk("set_wins_count", 32'(count), 4);
      in_valid = 1'b0; step(); clear_ovf = 1'b0;
      chk("clear_alone", 32'(overflow), 0);

      drive(1, OP_AND, 8'h77, 0); step();
      drive(0, OP_AND, 8'h00, 1); step();
      chk("pre_rst_count", 32'(count), 3);
      chk("pre_rst_overflow", 32'(overflow), 1);
      drive(1, OP_XOR, 8'h55, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_overflow", 32'(overflow), 0);
      chk("async_rst_in_ready", 32'(in_ready), 1);
      drive(0, OP_ADD, 8'h00, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, OP_SHL, 8'h3C, 0); step();
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_result", 32'(out_result), 32'h3C);
      chk("post_rst_op", 32'(out_op), 32'(OP_SHL));
      chk("post_rst_count", 32'(count), 1);

      for (int i = 0; i < 600; i++) begin
         int phase;
         phase = (i / 50) % 3;
         in_valid  = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 2 : 5)));
         out_ready = ($urandom_range(0, 9) < (phase == 0 ? 2 : (phase == 1 ? 8 : 5)));
         in_op     = 4'($urandom_range(0, 7));
         in_result = 8'($urandom);
         clear_ovf = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
